// File: rtl/dcache_array_nway_pkg.sv
// ---------------------------------------------------------------------------
// dcache_array_nway_pkg
// Shared constants and types for the N-way set-associative data cache array.
// Holds the default geometry (sets, ways, tag and line widths), the index,
// tag and way typedefs for that geometry, and a helper that sizes way
// numbers and LRU ages.
// ---------------------------------------------------------------------------
package dcache_array_nway_pkg;

  localparam int DCACHE_SETS      = 16;
  localparam int DCACHE_WAYS      = 4;
  localparam int DCACHE_TAG_BITS  = 22;
  localparam int DCACHE_DATA_BITS = 64;
  localparam int DCACHE_IDX_BITS  = $clog2(DCACHE_SETS);

  // A way number always needs at least one bit, even when the cache is
  // direct-mapped and there is only a single way.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  localparam int DCACHE_WAY_BITS = way_bits(DCACHE_WAYS);

  typedef logic [DCACHE_IDX_BITS-1:0] dc_idx_t;
  typedef logic [DCACHE_TAG_BITS-1:0] dc_tag_t;
  typedef logic [DCACHE_WAY_BITS-1:0] dc_way_t;

endpackage

// File: rtl/dcache_lru_set.sv
// ---------------------------------------------------------------------------
// dcache_lru_set
// One set of the cache: WAYS lines of tag, data and valid bit, plus one
// true-LRU age per way (0 = most recently used).
// Ports:
//   clock, reset              - clock and async active-high reset
//   i_rd_act                  - this set is being read with the cache enabled
//   i_rd_tag                  - lookup tag; o_rd_hit/o_rd_way/o_rd_data result
//   i_wr_en, i_wr_tag/data    - write or fill into this set
//   o_evict_valid/tag/data    - valid line displaced by the current write
//   i_inv_en, i_inv_tag       - invalidate the line holding i_inv_tag
// ---------------------------------------------------------------------------
module dcache_lru_set
  import dcache_array_nway_pkg::*;
#(
  parameter  int WAYS      = DCACHE_WAYS,
  parameter  int TAG_BITS  = DCACHE_TAG_BITS,
  parameter  int DATA_BITS = DCACHE_DATA_BITS,
  localparam int WAY_BITS  = way_bits(WAYS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_rd_act,
  input  logic [TAG_BITS-1:0]  i_rd_tag,
  output logic                 o_rd_hit,
  output logic [WAY_BITS-1:0]  o_rd_way,
  output logic [DATA_BITS-1:0] o_rd_data,
  input  logic                 i_wr_en,
  input  logic [TAG_BITS-1:0]  i_wr_tag,
  input  logic [DATA_BITS-1:0] i_wr_data,
  output logic                 o_evict_valid,
  output logic [TAG_BITS-1:0]  o_evict_tag,
  output logic [DATA_BITS-1:0] o_evict_data,
  input  logic                 i_inv_en,
  input  logic [TAG_BITS-1:0]  i_inv_tag
);

  typedef logic [WAYS-1:0][WAY_BITS-1:0] age_vec_t;

  logic [WAYS-1:0]      r_valid;
  logic [TAG_BITS-1:0]  r_tag  [WAYS];
  logic [DATA_BITS-1:0] r_data [WAYS];

  logic                w_wr_hit;
  logic [WAY_BITS-1:0] w_wr_hit_way;
  logic                w_has_free;
  logic [WAY_BITS-1:0] w_free_way;
  logic [WAY_BITS-1:0] w_lru_way;
  logic [WAY_BITS-1:0] w_wr_way;
  logic                w_inv_hit;
  logic [WAY_BITS-1:0] w_inv_way;

  // Move way w to MRU; every way younger than w's old age ages by one, so
  // the ages stay a permutation of 0..WAYS-1.
  function automatic age_vec_t touch(input age_vec_t a, input logic [WAY_BITS-1:0] w);
    age_vec_t r;
    r = a;
    for (int i = 0; i < WAYS; i++) begin
      if (a[i] < a[w]) r[i] = a[i] + WAY_BITS'(1);
    end
    r[w] = '0;
    return r;
  endfunction

  // Tag lookups for read, write and invalidate. A tag is never valid in two
  // ways, so the first match is the only match.
  always_comb begin
    o_rd_hit     = 1'b0;
    o_rd_way     = '0;
    o_rd_data    = '0;
    w_wr_hit     = 1'b0;
    w_wr_hit_way = '0;
    w_inv_hit    = 1'b0;
    w_inv_way    = '0;
    w_has_free   = 1'b0;
    w_free_way   = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (r_valid[i] && r_tag[i] == i_rd_tag && !o_rd_hit) begin
        o_rd_hit  = 1'b1;
        o_rd_way  = WAY_BITS'(i);
        o_rd_data = r_data[i];
      end
      if (r_valid[i] && r_tag[i] == i_wr_tag && !w_wr_hit) begin
        w_wr_hit     = 1'b1;
        w_wr_hit_way = WAY_BITS'(i);
      end
      if (r_valid[i] && r_tag[i] == i_inv_tag && !w_inv_hit) begin
        w_inv_hit = 1'b1;
        w_inv_way = WAY_BITS'(i);
      end
      if (!r_valid[i] && !w_has_free) begin
        w_has_free = 1'b1;
        w_free_way = WAY_BITS'(i);
      end
    end
  end

  // Write target: the hit way, else the lowest free way, else the LRU way.
  // Only a miss into a full set displaces a valid line.
  always_comb begin
    w_wr_way      = w_wr_hit ? w_wr_hit_way : (w_has_free ? w_free_way : w_lru_way);
    o_evict_valid = i_wr_en && !w_wr_hit && (&r_valid);
    o_evict_tag   = o_evict_valid ? r_tag[w_lru_way]  : '0;
    o_evict_data  = o_evict_valid ? r_data[w_lru_way] : '0;
  end

  // Valid bits: the invalidate clear is applied before the write set, so a
  // write to the same tag in the same cycle keeps the line valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      if (i_inv_en && w_inv_hit) r_valid[w_inv_way] <= 1'b0;
      if (i_wr_en)               r_valid[w_wr_way]  <= 1'b1;
    end
  end

  // Tag and data storage carries no reset; a write in a reset cycle is
  // dropped so the arrays never see it.
  always_ff @(posedge clock) begin
    if (i_wr_en && !reset) begin
      r_tag[w_wr_way]  <= i_wr_tag;
      r_data[w_wr_way] <= i_wr_data;
    end
  end

  if (WAYS > 1) begin : g_lru
    age_vec_t r_age;
    age_vec_t w_age_rd;
    age_vec_t w_age_nxt;

    // A read hit ages the set first, then the write, so a written way
    // always finishes the cycle as MRU.
    always_comb begin
      w_age_rd = r_age;
      if (i_rd_act && o_rd_hit) w_age_rd = touch(r_age, o_rd_way);
      w_age_nxt = w_age_rd;
      if (i_wr_en) w_age_nxt = touch(w_age_rd, w_wr_way);
    end

    // The LRU way is the one holding the oldest age.
    always_comb begin
      w_lru_way = '0;
      for (int i = 0; i < WAYS; i++) begin
        if (r_age[i] == WAY_BITS'(WAYS - 1)) w_lru_way = WAY_BITS'(i);
      end
    end

    // Ages restart as the identity permutation on reset.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < WAYS; i++) r_age[i] <= WAY_BITS'(i);
      end else begin
        r_age <= w_age_nxt;
      end
    end
  end else begin : g_direct
    assign w_lru_way = '0;
  end

endmodule

// File: rtl/dcache_array_nway.sv
// ---------------------------------------------------------------------------
// dcache_array_nway
// N-way set-associative data cache array with true-LRU replacement.
// Ports:
//   clock, reset                   - clock and async active-high reset
//   en                             - global access enable (gates all updates)
//   wr1_en/idx/tag/data            - fill or overwrite request
//   rd1_idx/tag                    - combinational lookup
//   rd1_data/valid/way             - lookup result, all zero on a miss
//   inv_en/idx/tag                 - invalidate request
//   evict_valid/tag/data           - valid line displaced by the current write
// ---------------------------------------------------------------------------
module dcache_array_nway
  import dcache_array_nway_pkg::*;
#(
  parameter  int SETS      = DCACHE_SETS,
  parameter  int WAYS      = DCACHE_WAYS,
  parameter  int TAG_BITS  = DCACHE_TAG_BITS,
  parameter  int DATA_BITS = DCACHE_DATA_BITS,
  localparam int IDX_BITS  = $clog2(SETS),
  localparam int WAY_BITS  = way_bits(WAYS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 wr1_en,
  input  logic [IDX_BITS-1:0]  wr1_idx,
  input  logic [TAG_BITS-1:0]  wr1_tag,
  input  logic [DATA_BITS-1:0] wr1_data,
  input  logic [IDX_BITS-1:0]  rd1_idx,
  input  logic [TAG_BITS-1:0]  rd1_tag,
  output logic [DATA_BITS-1:0] rd1_data,
  output logic                 rd1_valid,
  output logic [WAY_BITS-1:0]  rd1_way,
  input  logic                 inv_en,
  input  logic [IDX_BITS-1:0]  inv_idx,
  input  logic [TAG_BITS-1:0]  inv_tag,
  output logic                 evict_valid,
  output logic [TAG_BITS-1:0]  evict_tag,
  output logic [DATA_BITS-1:0] evict_data
);

  logic [SETS-1:0]      w_rd_hit;
  logic [WAY_BITS-1:0]  w_rd_way   [SETS];
  logic [DATA_BITS-1:0] w_rd_data  [SETS];
  logic [SETS-1:0]      w_ev_valid;
  logic [TAG_BITS-1:0]  w_ev_tag   [SETS];
  logic [DATA_BITS-1:0] w_ev_data  [SETS];

  for (genvar s = 0; s < SETS; s++) begin : g_set
    logic w_sel_rd;
    logic w_sel_wr;
    logic w_sel_inv;

    assign w_sel_rd  = en && (rd1_idx == IDX_BITS'(s));
    assign w_sel_wr  = en && wr1_en && (wr1_idx == IDX_BITS'(s));
    assign w_sel_inv = en && inv_en && (inv_idx == IDX_BITS'(s));

    dcache_lru_set #(
      .WAYS      (WAYS),
      .TAG_BITS  (TAG_BITS),
      .DATA_BITS (DATA_BITS)
    ) u_set (
      .clock         (clock),
      .reset         (reset),
      .i_rd_act      (w_sel_rd),
      .i_rd_tag      (rd1_tag),
      .o_rd_hit      (w_rd_hit[s]),
      .o_rd_way      (w_rd_way[s]),
      .o_rd_data     (w_rd_data[s]),
      .i_wr_en       (w_sel_wr),
      .i_wr_tag      (wr1_tag),
      .i_wr_data     (wr1_data),
      .o_evict_valid (w_ev_valid[s]),
      .o_evict_tag   (w_ev_tag[s]),
      .o_evict_data  (w_ev_data[s]),
      .i_inv_en      (w_sel_inv),
      .i_inv_tag     (inv_tag)
    );
  end

  // Each set already zeroes its outputs on a miss or when it is not the
  // write target, so a plain index mux is enough here.
  assign rd1_valid   = w_rd_hit[rd1_idx];
  assign rd1_way     = w_rd_way[rd1_idx];
  assign rd1_data    = w_rd_data[rd1_idx];
  assign evict_valid = w_ev_valid[wr1_idx];
  assign evict_tag   = w_ev_tag[wr1_idx];
  assign evict_data  = w_ev_data[wr1_idx];

endmodule

// File: tb/tb_dcache_array_nway.sv
// ---------------------------------------------------------------------------
// tb_dcache_array_nway
// Directed bench for dcache_array_nway at SETS=8, WAYS=4, TAG_BITS=10.
// Inputs change on the falling edge, outputs are sampled 1 time unit later,
// and state commits on the following rising edge.
// ---------------------------------------------------------------------------
module tb_dcache_array_nway;

  localparam int SETS      = 8;
  localparam int WAYS      = 4;
  localparam int TAG_BITS  = 10;
  localparam int DATA_BITS = 64;
  localparam int IDX_BITS  = 3;
  localparam int WAY_BITS  = 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 en;
  logic                 wr1_en;
  logic [IDX_BITS-1:0]  wr1_idx;
  logic [TAG_BITS-1:0]  wr1_tag;
  logic [DATA_BITS-1:0] wr1_data;
  logic [IDX_BITS-1:0]  rd1_idx;
  logic [TAG_BITS-1:0]  rd1_tag;
  logic [DATA_BITS-1:0] rd1_data;
  logic                 rd1_valid;
  logic [WAY_BITS-1:0]  rd1_way;
  logic                 inv_en;
  logic [IDX_BITS-1:0]  inv_idx;
  logic [TAG_BITS-1:0]  inv_tag;
  logic                 evict_valid;
  logic [TAG_BITS-1:0]  evict_tag;
  logic [DATA_BITS-1:0] evict_data;

  int errors = 0;
  int checks = 0;

  dcache_array_nway #(
    .SETS      (SETS),
    .WAYS      (WAYS),
    .TAG_BITS  (TAG_BITS),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .wr1_en      (wr1_en),
    .wr1_idx     (wr1_idx),
    .wr1_tag     (wr1_tag),
    .wr1_data    (wr1_data),
    .rd1_idx     (rd1_idx),
    .rd1_tag     (rd1_tag),
    .rd1_data    (rd1_data),
    .rd1_valid   (rd1_valid),
    .rd1_way     (rd1_way),
    .inv_en      (inv_en),
    .inv_idx     (inv_idx),
    .inv_tag     (inv_tag),
    .evict_valid (evict_valid),
    .evict_tag   (evict_tag),
    .evict_data  (evict_data)
  );

  always #5 clock = ~clock;

  // Guard against a stuck simulation.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

  // Fill data is derived from the tag so every line is distinguishable.
  function automatic logic [DATA_BITS-1:0] lineData(input logic [TAG_BITS-1:0] t);
    return 64'hA5A5_0000_0000_0000 | 64'(t);
  endfunction

  // Advance one full cycle, ending back on the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Return all request inputs to a quiet state with the cache enabled.
  task automatic applyStimulus();
    en       = 1'b1;
    wr1_en   = 1'b0;
    wr1_idx  = '0;
    wr1_tag  = '0;
    wr1_data = '0;
    rd1_idx  = '0;
    rd1_tag  = '0;
    inv_en   = 1'b0;
    inv_idx  = '0;
    inv_tag  = '0;
  endtask

  task automatic setWrite(input logic [IDX_BITS-1:0] idx, input logic [TAG_BITS-1:0] tag,
                          input logic [DATA_BITS-1:0] data);
    wr1_en   = 1'b1;
    wr1_idx  = idx;
    wr1_tag  = tag;
    wr1_data = data;
  endtask

  task automatic setRead(input logic [IDX_BITS-1:0] idx, input logic [TAG_BITS-1:0] tag);
    rd1_idx = idx;
    rd1_tag = tag;
  endtask

  // Outputs must be quiet while reset is held with a write pending.
  task automatic test_reset();
    reset = 1'b1;
    applyStimulus();
    setWrite(3'd1, 10'h3, 64'h1);
    setRead(3'd1, 10'h3);
    #2;
    checks++;
    if (rd1_valid !== 1'b0 || rd1_data !== '0 || rd1_way !== '0) begin
      errors++;
      $display("[TB] FAIL reset_read: got valid=%b data=%h way=%0d expected 0/0/0",
               rd1_valid, rd1_data, rd1_way);
    end
    checks++;
    if (evict_valid !== 1'b0 || evict_tag !== '0 || evict_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_evict: got valid=%b tag=%h data=%h expected all zero",
               evict_valid, evict_tag, evict_data);
    end
    @(negedge clock);
    reset = 1'b0;
    applyStimulus();
  endtask

  // Fill set 3 with 0x10..0x13 then read each back in way order.
  task automatic test_fill();
    for (int t = 0; t < 4; t++) begin
      setWrite(3'd3, 10'h10 + 10'(t), lineData(10'h10 + 10'(t)));
      #1;
      checks++;
      if (evict_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fill_evict%0d: got %b expected 0", t, evict_valid);
      end
      tick();
    end
    applyStimulus();
    for (int t = 0; t < 4; t++) begin
      setRead(3'd3, 10'h10 + 10'(t));
      #1;
      checks++;
      if (rd1_valid !== 1'b1 || rd1_way !== WAY_BITS'(t) || rd1_data !== lineData(10'h10 + 10'(t))) begin
        errors++;
        $display("[TB] FAIL fill_read%0d: got valid=%b way=%0d data=%h expected 1/%0d/%h",
                 t, rd1_valid, rd1_way, rd1_data, t, lineData(10'h10 + 10'(t)));
      end
      tick();
    end
  endtask

  // Touching 0x10 leaves 0x11 (way 1) as LRU, so 0x14 must evict it.
  task automatic test_evict();
    applyStimulus();
    setRead(3'd3, 10'h10);
    #1;
    checks++;
    if (rd1_valid !== 1'b1 || rd1_way !== 2'd0) begin
      errors++;
      $display("[TB] FAIL evict_pre_read: got valid=%b way=%0d expected 1/0", rd1_valid, rd1_way);
    end
    tick();
    applyStimulus();
    setWrite(3'd3, 10'h14, lineData(10'h14));
    #1;
    checks++;
    if (evict_valid !== 1'b1 || evict_tag !== 10'h11 || evict_data !== lineData(10'h11)) begin
      errors++;
      $display("[TB] FAIL evict_victim: got valid=%b tag=%h data=%h expected 1/011/%h",
               evict_valid, evict_tag, evict_data, lineData(10'h11));
    end
    tick();
    applyStimulus();
    setRead(3'd3, 10'h14);
    #1;
    checks++;
    if (rd1_valid !== 1'b1 || rd1_way !== 2'd1 || rd1_data !== lineData(10'h14)) begin
      errors++;
      $display("[TB] FAIL evict_landing: got valid=%b way=%0d data=%h expected 1/1/%h",
               rd1_valid, rd1_way, rd1_data, lineData(10'h14));
    end
    setRead(3'd3, 10'h11);
    #1;
    checks++;
    if (rd1_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL evict_gone: got valid=%b expected 0", rd1_valid);
    end
    tick();
  endtask

  // Overwriting a resident tag: no eviction, same way, old data seen until
  // the edge and the new data afterwards.
  task automatic test_write_hit();
    applyStimulus();
    setWrite(3'd3, 10'h12, 64'hDEAD_BEEF_0000_0012);
    setRead(3'd3, 10'h12);
    #1;
    checks++;
    if (evict_valid !== 1'b0 || evict_tag !== '0) begin
      errors++;
      $display("[TB] FAIL whit_evict: got valid=%b tag=%h expected 0/000", evict_valid, evict_tag);
    end
    checks++;
    if (rd1_data !== lineData(10'h12)) begin
      errors++;
      $display("[TB] FAIL whit_old_data: got %h expected %h", rd1_data, lineData(10'h12));
    end
    tick();
    wr1_en = 1'b0;
    #1;
    checks++;
    if (rd1_valid !== 1'b1 || rd1_way !== 2'd2 || rd1_data !== 64'hDEAD_BEEF_0000_0012) begin
      errors++;
      $display("[TB] FAIL whit_new_data: got valid=%b way=%0d data=%h expected 1/2/deadbeef00000012",
               rd1_valid, rd1_way, rd1_data);
    end
    tick();
  endtask

  // Invalidate way 3 then fill: the free way is reused with no eviction.
  task automatic test_invalidate();
    applyStimulus();
    inv_en  = 1'b1;
    inv_idx = 3'd3;
    inv_tag = 10'h13;
    tick();
    applyStimulus();
    setRead(3'd3, 10'h13);
    #1;
    checks++;
    if (rd1_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inv_cleared: got valid=%b expected 0", rd1_valid);
    end
    setRead(3'd0, 10'h0);
    setWrite(3'd3, 10'h20, lineData(10'h20));
    #1;
    checks++;
    if (evict_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inv_refill_evict: got %b expected 0", evict_valid);
    end
    tick();
    applyStimulus();
    setRead(3'd3, 10'h20);
    #1;
    checks++;
    if (rd1_valid !== 1'b1 || rd1_way !== 2'd3) begin
      errors++;
      $display("[TB] FAIL inv_refill_way: got valid=%b way=%0d expected 1/3", rd1_valid, rd1_way);
    end
    tick();
  endtask

  // Write and invalidate of the same line in one cycle: the write wins.
  task automatic test_wr_inv_same();
    applyStimulus();
    setWrite(3'd5, 10'h7, lineData(10'h7));
    tick();
    setWrite(3'd5, 10'h7, 64'h1234_5678_9ABC_DEF0);
    inv_en  = 1'b1;
    inv_idx = 3'd5;
    inv_tag = 10'h7;
    tick();
    applyStimulus();
    setRead(3'd5, 10'h7);
    #1;
    checks++;
    if (rd1_valid !== 1'b1 || rd1_data !== 64'h1234_5678_9ABC_DEF0) begin
      errors++;
      $display("[TB] FAIL wr_inv_same: got valid=%b data=%h expected 1/123456789abcdef0",
               rd1_valid, rd1_data);
    end
    tick();
  endtask

  // With en low nothing commits, but lookups still answer.
  task automatic test_enable_low();
    applyStimulus();
    en = 1'b0;
    setWrite(3'd6, 10'h40, lineData(10'h40));
    inv_en  = 1'b1;
    inv_idx = 3'd3;
    inv_tag = 10'h20;
    setRead(3'd3, 10'h20);
    #1;
    checks++;
    if (rd1_valid !== 1'b1 || rd1_way !== 2'd3 || evict_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL en_low_read: got valid=%b way=%0d evict=%b expected 1/3/0",
               rd1_valid, rd1_way, evict_valid);
    end
    tick();
    applyStimulus();
    setRead(3'd6, 10'h40);
    #1;
    checks++;
    if (rd1_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL en_low_write: got valid=%b expected 0", rd1_valid);
    end
    setRead(3'd3, 10'h20);
    #1;
    checks++;
    if (rd1_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL en_low_inv: got valid=%b expected 1", rd1_valid);
    end
    tick();
  endtask

  // Reset mid-operation: lines vanish at once, the pending write is
  // dropped, and fresh fills start in way 0.
  task automatic test_reset_mid();
    applyStimulus();
    setWrite(3'd2, 10'h55, lineData(10'h55));
    setRead(3'd3, 10'h20);
    reset = 1'b1;
    #1;
    checks++;
    if (rd1_valid !== 1'b0 || rd1_data !== '0) begin
      errors++;
      $display("[TB] FAIL rst_mid_read3: got valid=%b data=%h expected 0/0", rd1_valid, rd1_data);
    end
    setRead(3'd5, 10'h7);
    #1;
    checks++;
    if (rd1_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_read5: got valid=%b expected 0", rd1_valid);
    end
    tick();
    reset = 1'b0;
    applyStimulus();
    setRead(3'd2, 10'h55);
    #1;
    checks++;
    if (rd1_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_dropped: got valid=%b expected 0", rd1_valid);
    end
    setWrite(3'd3, 10'h30, lineData(10'h30));
    #1;
    checks++;
    if (evict_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_refill_evict: got %b expected 0", evict_valid);
    end
    tick();
    setWrite(3'd5, 10'h31, lineData(10'h31));
    setRead(3'd3, 10'h30);
    #1;
    checks++;
    if (rd1_valid !== 1'b1 || rd1_way !== 2'd0) begin
      errors++;
      $display("[TB] FAIL rst_refill_way3: got valid=%b way=%0d expected 1/0", rd1_valid, rd1_way);
    end
    tick();
    applyStimulus();
    setRead(3'd5, 10'h31);
    #1;
    checks++;
    if (rd1_valid !== 1'b1 || rd1_way !== 2'd0 || rd1_data !== lineData(10'h31)) begin
      errors++;
      $display("[TB] FAIL rst_refill_way5: got valid=%b way=%0d data=%h expected 1/0/%h",
               rd1_valid, rd1_way, rd1_data, lineData(10'h31));
    end
    tick();
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_fill();
    test_evict();
    test_write_hit();
    test_invalidate();
    test_wr_inv_same();
    test_enable_low();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_array_nway.md
DCACHE_ARRAY_NWAY -- requirements
Module: dcache_array_nway

Interface
REQ-001 Parameter SETS, default 16: number of sets; power of two, at least 2.
REQ-002 Parameter WAYS, default 4: associativity; power of two, 1..8.
REQ-003 Parameter TAG_BITS, default 22: tag width.
REQ-004 Parameter DATA_BITS, default 64: line width.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high; ports are named clock and reset.
REQ-006 The block SHALL have these ports (IDX_BITS=log2 SETS, WAY_BITS=max(1,log2 WAYS)):
- clock in 1: clock.
- reset in 1: async active-high reset.
- en in 1: global access enable.
- wr1_en in 1: fill/write request.
- wr1_idx in IDX_BITS: write set.
- wr1_tag in TAG_BITS: write tag.
- wr1_data in DATA_BITS: write data.
- rd1_idx in IDX_BITS: read set.
- rd1_tag in TAG_BITS: read tag.
- rd1_data out DATA_BITS: hit-way data.
- rd1_valid out 1: read hit.
- rd1_way out WAY_BITS: hit way.
- inv_en in 1: invalidate request.
- inv_idx in IDX_BITS: invalidate set.
- inv_tag in TAG_BITS: invalidate tag.
- evict_valid out 1: current write displaces a valid line.
- evict_tag out TAG_BITS: displaced tag.
- evict_data out DATA_BITS: displaced data.

Function
REQ-007 Reads SHALL be combinational: rd1_valid=1 iff some valid way in set rd1_idx holds rd1_tag; rd1_data and rd1_way come from that way, otherwise all zero.
REQ-008 The same {idx,tag} SHALL never be valid in two ways of one set.
REQ-009 Writes SHALL commit at the posedge with en&wr1_en and be visible from the next cycle. A same-cycle read of the written set SHALL see pre-write contents.
- Write hit: overwrite data in the matching way.
- Write miss: fill the lowest-numbered invalid way, else the LRU way; set valid, store tag and data.
REQ-010 evict_valid SHALL be combinational and equal en&wr1_en&miss&(all ways valid). evict_tag/evict_data SHALL show the victim's old contents; all zero when evict_valid=0.
REQ-011 Replacement SHALL be true LRU with one WAY_BITS age per way; age 0 means MRU.
- On access to way w: age[w]←0, and every way whose age is below w's old age increments.
- Ages in a set SHALL always be a permutation of 0..WAYS-1.
REQ-012 LRU update sources: read hit when en=1; write when en&wr1_en.
- Different sets: both update in the same cycle.
- Same set: read update is applied first, then write update, so the written way ends as MRU.
REQ-013 Invalidate SHALL act at the posedge with en&inv_en: clear the valid bit of the way in set inv_idx matching inv_tag, leaving ages unchanged; no match means no effect.
REQ-014 If an invalidate and a write target the same idx and tag in one cycle, the write SHALL win and the line stays valid.
REQ-015 With en=0, no state SHALL change; reads still operate.
REQ-016 WAYS=1 SHALL degenerate to direct-mapped: LRU logic is absent and rd1_way=0.

Reset
REQ-017 Asserting reset SHALL immediately clear all valid bits and set age[w]=w in every set; data and tag arrays are not reset.
REQ-018 During and right after reset, rd1_valid=0, rd1_data=0, rd1_way=0, evict_valid=0, evict_tag=0, evict_data=0.
REQ-019 Reset asserted mid-operation SHALL discard any write or invalidate in that cycle.

Structure
REQ-020 The shared package SHALL hold the DCACHE SETS/WAYS/TAG_BITS constants and the idx/tag/way typedefs.
REQ-021 The set logic SHALL be one sub-module, dcache_lru_set (WAYS ways: tags, data, valids, ages, hit/victim select), instantiated SETS times in a generate loop.

Verification (SETS=8, WAYS=4, TAG_BITS=10)
REQ-022 The bench SHALL cover these directed scenarios:
- Fill set 3 with tags 0x10..0x13 → next cycle, reads of each return rd1_valid=1 and rd1_way=0..3 respectively.
- Read 0x10, then write tag 0x14 to set 3 → evict_valid=1, evict_tag=0x11; 0x14 lands in way 1.
- Write tag 0x12 to set 3 with new data → no eviction; way 2 is updated; read returns the new data.
- Invalidate {3,0x13}, then write 0x20 → way 3 is filled and evict_valid=0.
- Same-cycle write and invalidate of {5,0x7} → line remains valid.
- Assert reset after fills → rd1_valid=0 everywhere immediately; the first write to any set uses way 0.
